periph_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single UART peripheral slave port between NUM_MASTERS bus masters (e.g. core data port, debug/loader master).
- Issues exactly one single-cycle request per transaction, waits for the slave response with a timeout, and routes rdata/rvalid back to the owner.
- Inserts one idle cycle between transactions so the peripheral can refresh its status/config bits, which it only updates while its request input is low.
- Sits between the masters' data bus and the peripheral slave port.

---
 rtl/soric_periph_pkg.sv | 18 +
 rtl/periph_rr_pick.sv | 30 +++
 rtl/periph_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_periph_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/soric_periph_pkg.sv
// Shared types and constants for the peripheral-side arbitration logic.
package soric_periph_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StGap   = 2'd3
    } periph_state_e;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 10;

    // UART register map offsets as seen on the slave port
    localparam logic [2:0] UartDataOffset = 3'h0;
    localparam logic [2:0] UartCfgOffset  = 3'h4;

endpackage

// File: rtl/periph_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from rr+1, wrapping.
module periph_rr_pick #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned IdxW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IdxW-1:0]        rr,
    output logic [IdxW-1:0]        winner,
    output logic                   valid
);

    int unsigned     pos;
    logic [IdxW-1:0] idx;

    // Scan from farthest to nearest so the nearest set bit after rr is written last.
    always_comb begin
        winner = '0;
        valid  = |req;
        pos    = 0;
        idx    = '0;
        for (int unsigned i = NUM_MASTERS; i >= 1; i--) begin
            pos = (32'(rr) + i) % NUM_MASTERS;
            idx = IdxW'(pos);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/periph_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port between several bus masters,
// issuing a single-cycle request per transaction with a response timeout.
module periph_arbiter
    import soric_periph_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_MASTERS-1:0]              m_req_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0]              m_gnt_o,
    output logic [NUM_MASTERS-1:0]              m_rvalid_o,
    output logic [NUM_MASTERS-1:0]              m_err_o,
    output logic [DATA_WIDTH-1:0]               m_rdata_o,
    output logic                                slave_data_req_o,
    output logic [ADDR_WIDTH-1:0]               slave_data_addr_o,
    output logic                                slave_data_we_o,
    output logic [DATA_WIDTH/8-1:0]             slave_data_be_o,
    output logic [DATA_WIDTH-1:0]               slave_data_wdata_o,
    input  logic                                slave_data_gnt_i,
    input  logic                                slave_data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]               slave_data_rdata_i
);

    localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned BeW  = DATA_WIDTH / 8;
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    periph_state_e state_q, state_d;
    logic [IdxW-1:0]        rr_q, rr_d, owner_q, owner_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   sreq_q, sreq_d, swe_q, swe_d;
    logic [ADDR_WIDTH-1:0]  saddr_q, saddr_d;
    logic [BeW-1:0]         sbe_q, sbe_d;
    logic [DATA_WIDTH-1:0]  swdata_q, swdata_d;

    logic [IdxW-1:0]       pick_idx;
    logic                  pick_valid;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_we;
    logic [BeW-1:0]        win_be;
    logic [DATA_WIDTH-1:0] win_wdata;

    // The slave completes on rvalid alone; its grant carries no information here.
    logic unused_slave_gnt;
    assign unused_slave_gnt = slave_data_gnt_i;

    periph_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IdxW        (IdxW)
    ) u_pick (
        .req    (m_req_i),
        .rr     (rr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (pick_idx == IdxW'(k)) begin
                win_addr  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                win_we    = m_we_i[k];
                win_be    = m_be_i[k*BeW +: BeW];
                win_wdata = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        sreq_d   = 1'b0;
        saddr_d  = saddr_q;
        swe_d    = swe_q;
        sbe_d    = sbe_q;
        swdata_d = swdata_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d  = pick_idx;
                    saddr_d  = win_addr;
                    swe_d    = win_we;
                    sbe_d    = win_be;
                    swdata_d = win_wdata;
                    sreq_d   = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (slave_data_rvalid_i) begin
                    rdata_d          = slave_data_rdata_i;
                    gnt_d[owner_q]   = 1'b1;
                    rvalid_d[owner_q] = 1'b1;
                    rr_d             = owner_q;
                    state_d          = StGap;
                end else if (cnt_q == TimeoutLast) begin
                    rdata_d           = '0;
                    gnt_d[owner_q]    = 1'b1;
                    rvalid_d[owner_q] = 1'b1;
                    err_d[owner_q]    = 1'b1;
                    rr_d              = owner_q;
                    state_d           = StGap;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // Owner still holds its request here; returning via IDLE avoids re-granting it.
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_q     <= IdxW'(NUM_MASTERS - 1);
            owner_q  <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            sreq_q   <= 1'b0;
            saddr_q  <= '0;
            swe_q    <= 1'b0;
            sbe_q    <= '0;
            swdata_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            sreq_q   <= sreq_d;
            saddr_q  <= saddr_d;
            swe_q    <= swe_d;
            sbe_q    <= sbe_d;
            swdata_q <= swdata_d;
        end
    end

    assign m_gnt_o            = gnt_q;
    assign m_rvalid_o         = rvalid_q;
    assign m_err_o            = err_q;
    assign m_rdata_o          = rdata_q;
    assign slave_data_req_o   = sreq_q;
    assign slave_data_addr_o  = saddr_q;
    assign slave_data_we_o    = swe_q;
    assign slave_data_be_o    = sbe_q;
    assign slave_data_wdata_o = swdata_q;

endmodule

// File: tb/tb_periph_arbiter.sv
// Directed bench for periph_arbiter with two masters and a hand-driven slave.
module tb_periph_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  m_req;
    logic [19:0] m_addr;
    logic [1:0]  m_we;
    logic [7:0]  m_be;
    logic [63:0] m_wdata;
    logic [1:0]  m_gnt;
    logic [1:0]  m_rvalid;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic        s_req;
    logic [9:0]  s_addr;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    logic        s_gnt;
    logic        s_rvalid;
    logic [31:0] s_rdata;

    int n_checks = 0;
    int n_errors = 0;

    periph_arbiter #(
        .NUM_MASTERS    (2),
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (10),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .m_req_i             (m_req),
        .m_addr_i            (m_addr),
        .m_we_i              (m_we),
        .m_be_i              (m_be),
        .m_wdata_i           (m_wdata),
        .m_gnt_o             (m_gnt),
        .m_rvalid_o          (m_rvalid),
        .m_err_o             (m_err),
        .m_rdata_o           (m_rdata),
        .slave_data_req_o    (s_req),
        .slave_data_addr_o   (s_addr),
        .slave_data_we_o     (s_we),
        .slave_data_be_o     (s_be),
        .slave_data_wdata_o  (s_wdata),
        .slave_data_gnt_i    (s_gnt),
        .slave_data_rvalid_i (s_rvalid),
        .slave_data_rdata_i  (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [1:0]  oh;
        logic [31:0] exp_data;
        logic [9:0]  exp_addr;

        reset    = 1'b1;
        m_req    = '0;
        m_addr   = '0;
        m_we     = '0;
        m_be     = '0;
        m_wdata  = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        repeat (2) step();
        check("rst_req", 32'(s_req), 32'h0);
        check("rst_gnt", 32'(m_gnt), 32'h0);
        check("rst_rvalid", 32'(m_rvalid), 32'h0);
        check("rst_rdata", m_rdata, 32'h0);
        reset = 1'b0;
        step();

        // Single write from master 0
        m_req   = 2'b01;
        m_we    = 2'b01;
        m_addr  = {10'h000, 10'h000};
        m_be    = {4'h0, 4'hF};
        m_wdata = {32'h0, 32'h41};
        step();
        check("wr_req", 32'(s_req), 32'h1);
        check("wr_addr", 32'(s_addr), 32'h000);
        check("wr_wdata", s_wdata, 32'h41);
        check("wr_be", 32'(s_be), 32'hF);
        check("wr_we", 32'(s_we), 32'h1);
        step();
        check("wr_req_pulse", 32'(s_req), 32'h0);
        check("wr_no_early_gnt", 32'(m_gnt), 32'h0);
        s_rvalid = 1'b1;
        s_rdata  = 32'h0000_00A5;
        step();
        check("wr_gnt", 32'(m_gnt), 32'h1);
        check("wr_rvalid", 32'(m_rvalid), 32'h1);
        check("wr_err", 32'(m_err), 32'h0);
        check("wr_rdata", m_rdata, 32'hA5);
        // Slave keeps rvalid high through GAP and IDLE: stale, must be ignored
        m_req = 2'b00;
        step();
        check("stale_gap_rvalid", 32'(m_rvalid), 32'h0);
        check("stale_gap_gnt", 32'(m_gnt), 32'h0);
        step();
        check("stale_idle_rvalid", 32'(m_rvalid), 32'h0);
        check("stale_idle_req", 32'(s_req), 32'h0);
        s_rvalid = 1'b0;

        // Timeout: both request, master 1 wins (master 0 served last)
        m_req  = 2'b11;
        m_we   = 2'b00;
        m_addr = {10'h004, 10'h000};
        step();
        check("to_req", 32'(s_req), 32'h1);
        check("to_addr", 32'(s_addr), 32'h004);
        lat = 0;
        while (m_gnt == 2'b00 && lat < 40) begin
            step();
            lat++;
        end
        check("to_latency", 32'(lat), 32'd16);
        check("to_gnt", 32'(m_gnt), 32'h2);
        check("to_rvalid", 32'(m_rvalid), 32'h2);
        check("to_err", 32'(m_err), 32'h2);
        check("to_rdata", m_rdata, 32'h0);
        m_req = 2'b01;
        step();
        check("to_gap_req", 32'(s_req), 32'h0);
        check("to_gap_err", 32'(m_err), 32'h0);
        step();
        check("to_next_req", 32'(s_req), 32'h1);
        check("to_next_addr", 32'(s_addr), 32'h000);

        // Rvalid arrives exactly on the timeout cycle
        repeat (15) step();
        check("coin_pre_gnt", 32'(m_gnt), 32'h0);
        s_rvalid = 1'b1;
        s_rdata  = 32'hCAFE_0001;
        step();
        check("coin_gnt", 32'(m_gnt), 32'h1);
        check("coin_rvalid", 32'(m_rvalid), 32'h1);
        check("coin_err", 32'(m_err), 32'h0);
        check("coin_rdata", m_rdata, 32'hCAFE_0001);
        s_rvalid = 1'b0;
        m_req    = 2'b00;
        step();

        // Asynchronous reset while waiting for the slave
        m_req  = 2'b01;
        m_addr = {10'h000, 10'h004};
        step();
        check("mr_req", 32'(s_req), 32'h1);
        check("mr_addr", 32'(s_addr), 32'h004);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("mr_addr_clr", 32'(s_addr), 32'h0);
        check("mr_rdata_clr", m_rdata, 32'h0);
        check("mr_gnt_clr", 32'(m_gnt), 32'h0);
        m_req    = 2'b11;
        s_rvalid = 1'b1;
        s_rdata  = 32'h1111_1111;
        step();
        check("mr_no_rvalid", 32'(m_rvalid), 32'h0);
        s_rvalid = 1'b0;
        reset    = 1'b0;

        // Contention: master 0 reads 0x004, master 1 reads 0x000, both held
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                oh       = 2'b01;
                exp_addr = 10'h004;
                exp_data = 32'h0001_2345;
            end else begin
                oh       = 2'b10;
                exp_addr = 10'h000;
                exp_data = 32'h0000_0055;
            end
            step();
            check("cont_req", 32'(s_req), 32'h1);
            check("cont_addr", 32'(s_addr), 32'(exp_addr));
            check("cont_we", 32'(s_we), 32'h0);
            step();
            check("cont_req_pulse", 32'(s_req), 32'h0);
            s_rvalid = 1'b1;
            s_rdata  = exp_data;
            step();
            check("cont_gnt", 32'(m_gnt), 32'(oh));
            check("cont_rvalid", 32'(m_rvalid), 32'(oh));
            check("cont_rdata", m_rdata, exp_data);
            s_rvalid = 1'b0;
            step();
            check("cont_gap_gnt", 32'(m_gnt), 32'h0);
            check("cont_gap_req", 32'(s_req), 32'h0);
        end
        m_req = 2'b00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
